// File: rtl/max_pool_stream_ctrl.sv
// Global max-pooling controller: streams CHANNELS x BIT_WIDTH pixels, keeps a
// per-channel running max over an H*W frame and hands the pooled vector downstream.
module max_pool_stream_ctrl #(
    parameter int H         = 4,
    parameter int W         = 4,
    parameter int CHANNELS  = 32,
    parameter int BIT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [CHANNELS*BIT_WIDTH-1:0]   pix_data,
    input  logic                            pix_last,
    output logic                            fv_valid,
    input  logic                            fv_ready,
    output logic [CHANNELS*BIT_WIDTH-1:0]   feature_vector,
    output logic                            busy,
    output logic                            frame_err,
    output logic [$clog2(H*W+1)-1:0]        pix_count
);

    localparam int N  = H * W;
    localparam int CW = $clog2(N + 1);
    localparam int DW = CHANNELS * BIT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pix_count_q, pix_count_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   feature_vector_q, feature_vector_d;
    logic            frame_err_q, frame_err_d;
    logic [DW-1:0]   acc_merged;
    logic            pix_hs;
    logic            at_last;

    assign pix_hs  = (state_q == ACCUM) && pix_valid;
    assign at_last = (pix_count_q == LAST_IDX);

    // First pixel of a frame loads outright so no stale max leaks in.
    always_comb begin
        acc_merged = acc_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if ((pix_count_q == '0) ||
                (pix_data[c*BIT_WIDTH +: BIT_WIDTH] > acc_q[c*BIT_WIDTH +: BIT_WIDTH])) begin
                acc_merged[c*BIT_WIDTH +: BIT_WIDTH] = pix_data[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        pix_count_d      = pix_count_q;
        acc_d            = acc_q;
        feature_vector_d = feature_vector_q;
        frame_err_d      = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCUM;
                    pix_count_d = '0;
                    frame_err_d = 1'b0;
                end
            end
            ACCUM: begin
                if (pix_hs) begin
                    acc_d       = acc_merged;
                    pix_count_d = pix_count_q + CW'(1);
                    if (pix_last != at_last) begin
                        frame_err_d = 1'b1;
                    end
                    if (at_last) begin
                        state_d          = OUT;
                        feature_vector_d = acc_merged;
                    end
                end
            end
            OUT: begin
                if (fv_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pix_count_q      <= '0;
            acc_q            <= '0;
            feature_vector_q <= '0;
            frame_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pix_count_q      <= pix_count_d;
            acc_q            <= acc_d;
            feature_vector_q <= feature_vector_d;
            frame_err_q      <= frame_err_d;
        end
    end

    assign pix_ready      = (state_q == ACCUM);
    assign fv_valid       = (state_q == OUT);
    assign busy           = (state_q != IDLE);
    assign frame_err      = frame_err_q;
    assign pix_count      = pix_count_q;
    assign feature_vector = feature_vector_q;

endmodule

// File: tb/tb_max_pool_stream_ctrl.sv
// Bench for max_pool_stream_ctrl: random/directed frames against a frame-level
// max model, plus a directed H=W=1 instance.
module tb_max_pool_stream_ctrl;

    localparam int CH = 32;
    localparam int BW = 8;
    localparam int DW = CH * BW;
    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, pix_valid = 1'b0, pix_last = 1'b0, fv_ready = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready, fv_valid, busy, frame_err;
    logic [DW-1:0] feature_vector;
    logic [CW-1:0] pix_count;

    logic          start2 = 1'b0, pv2 = 1'b0, pl2 = 1'b0, fr2 = 1'b0;
    logic [DW-1:0] pd2 = '0;
    logic          pr2, fvv2, busy2, err2;
    logic [DW-1:0] fv2;
    logic [0:0]    cnt2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    max_pool_stream_ctrl #(.H(4), .W(4), .CHANNELS(CH), .BIT_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .fv_valid(fv_valid), .fv_ready(fv_ready), .feature_vector(feature_vector),
        .busy(busy), .frame_err(frame_err), .pix_count(pix_count)
    );

    max_pool_stream_ctrl #(.H(1), .W(1), .CHANNELS(CH), .BIT_WIDTH(BW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pix_valid(pv2),
        .pix_ready(pr2), .pix_data(pd2), .pix_last(pl2),
        .fv_valid(fvv2), .fv_ready(fr2), .feature_vector(fv2),
        .busy(busy2), .frame_err(err2), .pix_count(cnt2)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: phase, accepted pixels, error flag, last result.
    int            m_phase;  // 0 idle, 1 collecting, 2 presenting
    logic [DW-1:0] m_frame[$];
    int            m_cnt;
    logic          m_err;
    logic [DW-1:0] m_fv;

    function automatic logic [DW-1:0] frame_max();
        logic [DW-1:0] r;
        logic [DW-1:0] px;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int best;
            best = 0;
            foreach (m_frame[i]) begin
                int v;
                px = m_frame[i];
                v = int'(px[c*BW +: BW]);
                if (v > best) best = v;
            end
            r[c*BW +: BW] = best[BW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_frame.delete(); m_cnt = 0; m_err = 1'b0; m_fv = '0;
        end
        chk("pix_ready", {255'd0, pix_ready}, {255'd0, m_phase == 1});
        chk("fv_valid", {255'd0, fv_valid}, {255'd0, m_phase == 2});
        chk("busy", {255'd0, busy}, {255'd0, m_phase != 0});
        chk("frame_err", {255'd0, frame_err}, {255'd0, m_err});
        chk("pix_count", DW'(pix_count), DW'(m_cnt));
        chk("feature_vector", feature_vector, m_fv);
        if (rst_n) begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_frame.delete(); m_cnt = 0; m_err = 1'b0;
                end
                1: if (pix_valid) begin
                    m_frame.push_back(pix_data);
                    if (pix_last != (m_cnt == N - 1)) m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_phase = 2;
                        m_fv = frame_max();
                    end
                end
                default: if (fv_ready) m_phase = 0;
            endcase
        end
    end

    function automatic logic [DW-1:0] gen(input int pattern, input int p);
        logic [DW-1:0] d;
        for (int c = 0; c < CH; c++) begin
            int v;
            case (pattern)
                0: v = (p - 1) * 3 + c;
                1: begin
                    v = int'($urandom_range(0, 255));
                    if (c == 0) v = (p == 1) ? 'h7F : (p == 2) ? 'h80 : int'($urandom_range(0, 'h7F));
                    if (c == 31) v = 'hFF;
                end
                2: v = 'h5A;
                4: v = 'hF0;
                default: v = int'($urandom_range(0, 255));
            endcase
            d[c*BW +: BW] = v[BW-1:0];
        end
        return d;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int pattern, input int last_pos, input bit gaps, input int abort_after);
        for (int p = 1; p <= N; p++) begin
            bit accepted;
            int waited;
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    pix_data = DW'({$urandom, $urandom});
                    @(posedge clk); #1;
                end
            end
            pix_data  = gen(pattern, p);
            pix_last  = (p == last_pos);
            pix_valid = 1'b1;
            accepted  = 1'b0;
            waited    = 0;
            while (!accepted && waited < 20) begin
                @(negedge clk);
                accepted = pix_ready;
                @(posedge clk); #1;
                waited++;
            end
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            if (!accepted) chk("pix_accept_timeout", '0, 1);
            if (p == 7 && last_pos == 7) chk("err_after_p7", {255'd0, frame_err}, 1);
            if (p == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pix_ready", {255'd0, pix_ready}, 0);
                chk("rst_fv_valid", {255'd0, fv_valid}, 0);
                chk("rst_busy", {255'd0, busy}, 0);
                chk("rst_frame_err", {255'd0, frame_err}, 0);
                chk("rst_pix_count", DW'(pix_count), 0);
                chk("rst_feature_vector", feature_vector, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
    endtask

    task automatic wait_fv(input int hold);
        logic [DW-1:0] snap;
        int t;
        t = 0;
        while (!fv_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!fv_valid) chk("fv_timeout", '0, 1);
        snap = feature_vector;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("fv_stable", feature_vector, snap);
            chk("out_pix_ready", {255'd0, pix_ready}, 0);
        end
        fv_ready = 1'b1;
        @(posedge clk); #1;
        fv_ready = 1'b0;
        chk("fv_dropped", {255'd0, fv_valid}, 0);
        chk("fv_retained", feature_vector, snap);
    endtask

    initial begin
        logic [DW-1:0] exp_v;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame: ch c max is 45+c, result one cycle after the 16th accept.
        do_start();
        run_frame(0, 16, 1'b0, 0);
        for (int c = 0; c < CH; c++) exp_v[c*BW +: BW] = BW'(45 + c);
        chk("ramp_fv_valid", {255'd0, fv_valid}, 1);
        chk("ramp_result", feature_vector, exp_v);
        chk("ramp_err", {255'd0, frame_err}, 0);
        chk("ramp_count", DW'(pix_count), DW'(16));
        wait_fv(0);

        // Unsigned compare boundaries.
        do_start();
        run_frame(1, 16, 1'b0, 0);
        exp_v = feature_vector;
        chk("unsigned_ch0", DW'(exp_v[7:0]), DW'(8'h80));
        chk("unsigned_ch31", DW'(exp_v[31*BW +: BW]), DW'(8'hFF));
        wait_fv(1);
        do_start();
        run_frame(2, 16, 1'b0, 0);
        chk("equal_values", feature_vector, {CH{8'h5A}});
        wait_fv(0);

        // Random data with valid gaps and a long downstream stall.
        for (int f = 0; f < 3; f++) begin
            do_start();
            run_frame(3, 16, 1'b1, 0);
            wait_fv(10);
        end

        // Early pix_last and missing final pix_last.
        do_start();
        run_frame(3, 7, 1'b1, 0);
        chk("err_at_end", {255'd0, frame_err}, 1);
        wait_fv(2);
        chk("err_sticky_idle", {255'd0, frame_err}, 1);
        do_start();
        chk("err_cleared", {255'd0, frame_err}, 0);

        // Reset mid-frame, then a clean frame must not see the 0xF0 pixels.
        run_frame(4, 16, 1'b0, 9);
        do_start();
        run_frame(0, 16, 1'b1, 0);
        for (int c = 0; c < CH; c++) exp_v[c*BW +: BW] = BW'(45 + c);
        chk("post_reset_result", feature_vector, exp_v);
        wait_fv(0);

        // Single-pixel frame instance.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("n1_pix_ready", {255'd0, pr2}, 1);
        pv2 = 1'b1; pd2 = {CH{8'hA5}}; pl2 = 1'b1;
        @(posedge clk); #1;
        pv2 = 1'b0; pl2 = 1'b0;
        chk("n1_fv_valid", {255'd0, fvv2}, 1);
        chk("n1_result", fv2, {CH{8'hA5}});
        chk("n1_err", {255'd0, err2}, 0);
        chk("n1_count", DW'(cnt2), 1);
        start2 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("n1_start_in_out", {255'd0, fvv2}, 1);
            chk("n1_out_ready", {255'd0, pr2}, 0);
        end
        fr2 = 1'b1;
        @(posedge clk); #1;
        fr2 = 1'b0; start2 = 1'b0;
        chk("n1_idle_after_hs", {255'd0, busy2}, 0);
        chk("n1_fv_kept", fv2, {CH{8'hA5}});
        @(posedge clk); #1;
        chk("n1_start_ignored", {255'd0, busy2}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
